// File: rtl/fxp_pkg.sv
// fxp_pkg: shared definitions for the fixed-point to integer rounding pipeline.
//   - Rounding mode codes (codes 6 and 7 are reserved).
//   - saturate(): clamps a wide signed value into the signed range of 'ow' bits.
package fxp_pkg;

    localparam logic [2:0] MODE_FLOOR = 3'd0;
    localparam logic [2:0] MODE_CEIL  = 3'd1;
    localparam logic [2:0] MODE_HUP   = 3'd2;  // half toward +inf
    localparam logic [2:0] MODE_AWAY  = 3'd3;  // half away from zero
    localparam logic [2:0] MODE_EVEN  = 3'd4;  // half to even
    localparam logic [2:0] MODE_TRUNC = 3'd5;  // toward zero

    // Values arrive sign-extended to 64 bits, so any ow up to 63 works.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int unsigned      ow);
        logic signed [63:0] mx;
        logic signed [63:0] mn;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        mn = -(64'sd1 <<< (ow - 1));
        if (v > mx)      return mx;
        else if (v < mn) return mn;
        else             return v;
    endfunction

endpackage

// File: rtl/fxp_round_inc.sv
// fxp_round_inc: combinational rounding increment.
//   frac   : fraction bits of the sample
//   sign   : sign of the sample
//   fl_lsb : LSB of floor(sample), used by round-half-to-even
//   mode   : rounding mode code
//   inc    : 1 when the floor value must be bumped by one
//   err    : reserved mode code (result falls back to floor)
module fxp_round_inc
    import fxp_pkg::*;
#(
    parameter int FW = 1
) (
    input  logic [FW-1:0] frac,
    input  logic          sign,
    input  logic          fl_lsb,
    input  logic [2:0]    mode,
    output logic          inc,
    output logic          err
);
    localparam logic [FW-1:0] HALF = FW'(1) << (FW - 1);

    logic half, gt, nz;

    assign half = (frac == HALF);
    assign gt   = (frac > HALF);
    assign nz   = (frac != '0);

    always_comb begin
        inc = 1'b0;
        err = 1'b0;
        case (mode)
            MODE_FLOOR: inc = 1'b0;
            MODE_CEIL:  inc = nz;
            MODE_HUP:   inc = gt || half;
            MODE_AWAY:  inc = gt || (half && !sign);
            MODE_EVEN:  inc = gt || (half && fl_lsb);
            MODE_TRUNC: inc = nz && sign;
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/fxp_round_pipe.sv
// fxp_round_pipe: two-stage valid/ready pipeline converting signed fixed point
// (IW integer bits incl. sign, FW fraction bits) to a saturated OW-bit integer.
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data/in_mode : input stream (mode chosen per sample)
//   out_valid/out_ready           : output stream handshake
//   out_data                      : rounded, saturated integer
//   out_sat/out_inexact/out_err   : clamped / nonzero fraction / reserved mode
//   sat_cnt, cnt_clr              : sticky count of transferred saturated results
module fxp_round_pipe
    import fxp_pkg::*;
#(
    parameter int IW = 4,
    parameter int FW = 1,
    parameter int OW = 4,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IW+FW-1:0]     in_data,
    input  logic [2:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_inexact,
    output logic                 out_err,
    output logic [CW-1:0]        sat_cnt,
    input  logic                 cnt_clr
);
    logic                 s1_valid;
    logic signed [IW-1:0] s1_fl;
    logic [FW-1:0]        s1_frac;
    logic                 s1_sign;
    logic [2:0]           s1_mode;

    logic                 s2_adv;
    logic                 inc, err;
    logic signed [IW:0]   r;
    logic signed [63:0]   r64, rsat;

    // Output stage frees up when empty or draining; stage 1 can take a new
    // sample whenever it is empty or moving forward.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;

    fxp_round_inc #(.FW(FW)) u_inc (
        .frac   (s1_frac),
        .sign   (s1_sign),
        .fl_lsb (s1_fl[0]),
        .mode   (s1_mode),
        .inc    (inc),
        .err    (err)
    );

    // One extra bit so floor+1 at the top of the input range cannot wrap.
    assign r    = {s1_fl[IW-1], s1_fl} + $signed({{IW{1'b0}}, inc});
    assign r64  = 64'(r);
    assign rsat = saturate(r64, OW);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s1_fl       <= '0;
            s1_frac     <= '0;
            s1_sign     <= 1'b0;
            s1_mode     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_sat     <= 1'b0;
            out_inexact <= 1'b0;
            out_err     <= 1'b0;
            sat_cnt     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    // Upper IW bits are the arithmetic shift right by FW.
                    s1_fl   <= in_data[IW+FW-1:FW];
                    s1_frac <= in_data[FW-1:0];
                    s1_sign <= in_data[IW+FW-1];
                    s1_mode <= in_mode;
                end
            end

            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out_data    <= rsat[OW-1:0];
                    out_sat     <= (rsat != r64);
                    out_inexact <= (s1_frac != '0);
                    out_err     <= err;
                end
            end

            if (cnt_clr)
                sat_cnt <= '0;
            else if (out_valid && out_ready && out_sat && (sat_cnt != '1))
                sat_cnt <= sat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fxp_round_pipe.sv
module tb_fxp_round_pipe;
    localparam int IW = 4;
    localparam int FW = 1;
    localparam int OW = 4;
    localparam int CW = 4;
    localparam int SCALE = 1 << FW;
    localparam int OMAX = (1 << (OW - 1)) - 1;
    localparam int OMIN = -(1 << (OW - 1));
    localparam int CMAX = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [IW+FW-1:0]     in_data = '0;
    logic [2:0]           in_mode = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic signed [OW-1:0] out_data;
    logic                 out_sat, out_inexact, out_err;
    logic [CW-1:0]        sat_cnt;
    logic                 cnt_clr = 1'b0;

    fxp_round_pipe #(.IW(IW), .FW(FW), .OW(OW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .out_inexact(out_inexact), .out_err(out_err),
        .sat_cnt(sat_cnt), .cnt_clr(cnt_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        bit sat;
        bit inex;
        bit err;
        int stamp;
    } exp_t;

    exp_t q[$];
    int   ncmp = 0;
    int   nerr = 0;
    int   ncyc = 0;
    int   msat = 0;
    bit   chk_lat = 1'b0;
    bit   held = 1'b0;
    int   held_data = 0;

    task automatic chk(input string tag, input int got, input int exp);
        ncmp++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: x is the sample scaled by 2^FW; rounding from the mode rules.
    function automatic exp_t model(input int x, input int m);
        exp_t e;
        int q0, rem, v;
        q0 = x / SCALE;
        if ((x % SCALE != 0) && (x < 0)) q0 = q0 - 1;
        rem = x - q0 * SCALE;               // 0 .. SCALE-1
        v = q0;
        case (m)
            1: if (rem != 0) v = q0 + 1;
            2: if (2 * rem >= SCALE) v = q0 + 1;
            3: if (2 * rem > SCALE || (2 * rem == SCALE && x >= 0)) v = q0 + 1;
            4: if (2 * rem > SCALE || (2 * rem == SCALE && (q0 % 2 != 0))) v = q0 + 1;
            5: if (rem != 0 && x < 0) v = q0 + 1;
            default: v = q0;
        endcase
        e.sat = (v > OMAX) || (v < OMIN);
        e.val = (v > OMAX) ? OMAX : (v < OMIN) ? OMIN : v;
        e.inex = (rem != 0);
        e.err = (m >= 6);
        e.stamp = 0;
        return e;
    endfunction

    task automatic cycle(input bit v, input int x, input int m, input bit ordy,
                         input bit clr, output bit acc);
        exp_t e;
        bit   incr;
        in_valid  = v;
        in_data   = x[IW+FW-1:0];
        in_mode   = m[2:0];
        out_ready = ordy;
        cnt_clr   = clr;
        @(negedge clk);
        chk("sat_cnt", int'(sat_cnt), msat);
        chk("in_ready", int'(in_ready), int'(!(q.size() == 2 && !ordy)));
        if (q.size() == 0) chk("idle_valid", int'(out_valid), 0);
        if (q.size() == 2) chk("full_valid", int'(out_valid), 1);
        if (held && out_valid) chk("stall_hold", int'(out_data), held_data);
        incr = 1'b0;
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("out_data", int'(out_data), e.val);
                chk("out_sat", int'(out_sat), int'(e.sat));
                chk("out_inexact", int'(out_inexact), int'(e.inex));
                chk("out_err", int'(out_err), int'(e.err));
                if (chk_lat) chk("latency", ncyc - e.stamp, 2);
                incr = e.sat;
            end
        end
        if (clr) msat = 0;
        else if (incr && msat != CMAX) msat++;
        held = out_valid && !ordy;
        held_data = int'(out_data);
        acc = v && in_ready;
        if (acc) begin
            e = model(x, m);
            e.stamp = ncyc;
            q.push_back(e);
        end
        ncyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 20 && q.size() != 0; i++) cycle(1'b0, 0, 0, 1'b1, 1'b0, acc);
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        msat = 0;
        held = 1'b0;
    endtask

    initial begin
        bit acc;
        int bx, bm, sent, k;

        do_reset(2);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_out_inexact", int'(out_inexact), 0);
        chk("rst_out_err", int'(out_err), 0);
        chk("rst_sat_cnt", int'(sat_cnt), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Full sweep of every input code under modes 0-5, streaming.
        chk_lat = 1'b1;
        for (int m = 0; m < 6; m++)
            for (int x = -(1 << (IW + FW - 1)); x < (1 << (IW + FW - 1)); x++)
                cycle(1'b1, x, m, 1'b1, 1'b0, acc);
        drain();

        // Saturation corners with a fresh counter.
        cycle(1'b0, 0, 0, 1'b1, 1'b1, acc);
        cycle(1'b1, 15, 1, 1'b1, 1'b0, acc);    // 7.5 ceil -> 8 -> clamp 7
        cycle(1'b1, -16, 0, 1'b1, 1'b0, acc);   // -8.0 floor -> -8
        drain();
        chk("sat_cnt_after_corners", int'(sat_cnt), 1);

        // Reserved modes and half-to-even.
        cycle(1'b1, -5, 6, 1'b1, 1'b0, acc);
        cycle(1'b1, -5, 7, 1'b1, 1'b0, acc);
        cycle(1'b1, 7, 4, 1'b1, 1'b0, acc);
        cycle(1'b1, 3, 4, 1'b1, 1'b0, acc);
        drain();

        // Backpressure: 6 samples, out_ready pattern 1,0,0,...
        chk_lat = 1'b0;
        sent = 0;
        k = 0;
        bx = int'($urandom_range(0, 31)) - 16;
        bm = int'($urandom_range(0, 7));
        while (sent < 6 && k < 60) begin
            cycle(1'b1, bx, bm, (k % 3 == 0), 1'b0, acc);
            if (acc) begin
                sent++;
                bx = int'($urandom_range(0, 31)) - 16;
                bm = int'($urandom_range(0, 7));
            end
            k++;
        end
        chk("bp_sent", sent, 6);
        drain();

        // Random valid/ready/clear traffic.
        for (int i = 0; i < 300; i++)
            cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, 31)) - 16,
                  int'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, acc);
        drain();

        // Counter sticks at all-ones.
        chk_lat = 1'b1;
        cycle(1'b0, 0, 0, 1'b1, 1'b1, acc);
        for (int i = 0; i < (1 << CW) + 3; i++) cycle(1'b1, 15, 1, 1'b1, 1'b0, acc);
        drain();
        chk("sat_cnt_stick", int'(sat_cnt), CMAX);
        // Clear coincides with a saturating output transfer.
        cycle(1'b1, 15, 1, 1'b1, 1'b0, acc);
        cycle(1'b0, 0, 0, 1'b1, 1'b0, acc);
        cycle(1'b0, 0, 0, 1'b1, 1'b1, acc);
        chk("sat_cnt_clr_prio", int'(sat_cnt), 0);

        // Reset with two samples in flight.
        cycle(1'b1, 15, 1, 1'b1, 1'b0, acc);
        drain();
        cycle(1'b1, 5, 0, 1'b0, 1'b0, acc);
        cycle(1'b1, -7, 2, 1'b0, 1'b0, acc);
        do_reset(1);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_sat_cnt", int'(sat_cnt), 0);
        @(posedge clk);
        #1;
        ncyc++;
        cycle(1'b1, 3, 0, 1'b1, 1'b0, acc);     // 1.5 floor -> 1
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
